// File: rtl/jtag_debug_host.sv
// jtag_debug_host: command-driven JTAG scan engine for one target TAP.
// Each command becomes a TMS/TDI tick sequence; TDO bits seen while shifting come back as a response.
module jtag_debug_host #(
    parameter int TCK_DIV = 2,
    parameter int MAX_LEN = 38
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_error,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, TLR_WALK, HEADER, SHIFT, TRAILER, RESP} state_t;
    localparam logic [7:0] DIV_LAST = 8'(TCK_DIV - 1);
    localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);
    state_t             state_q, state_d;
    logic [7:0]         div_q;
    logic [5:0]         idx_q, len_q, last_idx, idx_d;
    logic [1:0]         op_q;
    logic [MAX_LEN-1:0] data_q, rsp_q;
    logic               tck_q, tms_q, tdi_q, err_q, rsp_en_q;
    logic               last, bad_cmd, tms_d, tdi_d;
    assign cmd_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_data  = rsp_q;
    assign rsp_error = err_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign bad_cmd   = cmd_len == 6'd0 || {1'b0, cmd_len} > LEN_MAX || cmd_op == 2'b11;
    // Index of the final tick in the current tick-generating state.
    assign last_idx  = state_q == TLR_WALK ? 6'd5 :
                       state_q == HEADER   ? (op_q == 2'b01 ? 6'd3 : 6'd2) :
                       state_q == SHIFT    ? len_q - 6'd1 : 6'd1;
    assign last      = idx_q == last_idx;
    assign idx_d     = last ? 6'd0 : idx_q + 6'd1;
    assign state_d   = !last                ? state_q :
                       state_q == TLR_WALK ? (rsp_en_q ? RESP : IDLE) :
                       state_q == HEADER   ? SHIFT :
                       state_q == SHIFT    ? TRAILER : RESP;
    // Pin values for the tick that starts on the edge ending the current one.
    assign tms_d     = state_d == TLR_WALK ? idx_d < 6'd5 :
                       state_d == HEADER   ? idx_d < (op_q == 2'b01 ? 6'd2 : 6'd1) :
                       state_d == SHIFT    ? idx_d == len_q - 6'd1 :
                       state_d == TRAILER  ? idx_d == 6'd0 : 1'b0;
    assign tdi_d     = state_d == SHIFT && data_q[idx_d];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= TLR_WALK;
            div_q    <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            op_q     <= '0;
            data_q   <= '0;
            rsp_q    <= '0;
            tck_q    <= 1'b0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b0;
            err_q    <= 1'b0;
            rsp_en_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cmd_valid) begin
                    op_q     <= cmd_op;
                    len_q    <= cmd_len;
                    data_q   <= cmd_data;
                    rsp_q    <= '0;
                    err_q    <= bad_cmd;
                    rsp_en_q <= 1'b1;
                    div_q    <= '0;
                    idx_q    <= '0;
                    if (bad_cmd) begin
                        state_q <= RESP;
                    end else begin
                        state_q <= cmd_op == 2'b00 ? TLR_WALK : HEADER;
                        tms_q   <= 1'b1;
                        tdi_q   <= 1'b0;
                    end
                end
                RESP: if (rsp_ready) begin
                    state_q <= IDLE;
                    err_q   <= 1'b0;
                end
                default: if (div_q != DIV_LAST) begin
                    div_q <= div_q + 8'd1;
                end else begin
                    div_q <= '0;
                    tck_q <= !tck_q;
                    if (!tck_q) begin
                        if (state_q == SHIFT) rsp_q[idx_q] <= tdo;
                    end else begin
                        state_q <= state_d;
                        idx_q   <= idx_d;
                        tms_q   <= tms_d;
                        tdi_q   <= tdi_d;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_debug_host.sv
// tb_jtag_debug_host: directed checks of the JTAG host against a small TAP model
// that loops tdi to tdo through one capture-preloaded stage, or ties tdo high.
module tb_jtag_debug_host;
    localparam int MAX_LEN = 38;
    localparam int RTI = 1;
    localparam logic [MAX_LEN-1:0] DR_DATA = 38'h2A_5A5A_5A5A;
    logic clk = 0, reset = 1, cmd_valid = 0, rsp_ready = 0, tie1 = 0;
    logic [1:0] cmd_op = 0;
    logic [5:0] cmd_len = 0;
    logic [MAX_LEN-1:0] cmd_data = 0;
    logic cmd_ready, rsp_valid, rsp_error, tck, tms, tdi, tdo, busy;
    logic [MAX_LEN-1:0] rsp_data;
    int total = 0, bad = 0, base = 0, tick_cnt = 0, tap = 0;
    logic stage = 1'b1;
    logic tms_hist [0:4095];
    logic tdi_hist [0:4095];

    jtag_debug_host #(.TCK_DIV(2), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy)
    );

    always #5 clk = ~clk;
    assign tdo = tie1 ? 1'b1 : stage;

    function automatic int tap_next(input int s, input logic m);
        case (s)
            0: return m ? 0 : 1;    1: return m ? 2 : 1;
            2: return m ? 9 : 3;    3: return m ? 5 : 4;
            4: return m ? 5 : 4;    5: return m ? 8 : 6;
            6: return m ? 7 : 6;    7: return m ? 8 : 4;
            8: return m ? 2 : 1;    9: return m ? 0 : 10;
            10: return m ? 12 : 11; 11: return m ? 12 : 11;
            12: return m ? 15 : 13; 13: return m ? 14 : 13;
            14: return m ? 15 : 11; default: return m ? 2 : 1;
        endcase
    endfunction

    always @(posedge tck) begin
        tms_hist[tick_cnt] <= tms;
        tdi_hist[tick_cnt] <= tdi;
        if (tap == 3 || tap == 10) stage <= 1'b1;
        else if (tap == 4 || tap == 11) stage <= tdi;
        tap <= tap_next(tap, tms);
        tick_cnt <= tick_cnt + 1;
    end

    function automatic logic [63:0] seq(input bit use_tdi, input int from, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = use_tdi ? tdi_hist[from + i] : tms_hist[from + i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [MAX_LEN-1:0] data);
        int n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 1);
        cmd_valid = 1; cmd_op = op; cmd_len = len; cmd_data = data;
        base = tick_cnt;
        @(negedge clk);
        cmd_valid = 0; cmd_op = 2'b11; cmd_len = 0; cmd_data = '1;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rsp_wait", 64'(rsp_valid), 1);
    endtask

    task automatic handshake();
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("after_hs", 64'({rsp_valid, cmd_ready}), 64'b01);
    endtask

    task automatic walk_check(input string tag);
        int cyc = 0;
        bit saw = 0;
        base = tick_cnt;
        reset = 0;
        while (!cmd_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
            saw |= rsp_valid;
        end
        check({tag, "_cycles"}, 64'(cyc), 24);
        check({tag, "_ticks"}, 64'(tick_cnt - base), 6);
        check({tag, "_tms"}, seq(0, base, 6), 64'h1F);
        check({tag, "_tdi"}, seq(1, base, 6), 0);
        check({tag, "_no_rsp"}, 64'(saw), 0);
        check({tag, "_tap"}, 64'(tap), RTI);
    endtask

    task automatic err_case(input string tag, input logic [1:0] op, input logic [5:0] len);
        send(op, len, '1);
        check({tag, "_valid"}, 64'(rsp_valid), 1);
        check({tag, "_err"}, 64'(rsp_error), 1);
        check({tag, "_data"}, 64'(rsp_data), 0);
        check({tag, "_noticks"}, 64'(tick_cnt - base), 0);
        handshake();
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_pins", 64'({tck, tms, tdi}), 64'b010);
        check("rst_rsp", 64'({rsp_valid, rsp_error, rsp_data}), 0);
        check("rst_ready_busy", 64'({cmd_ready, busy}), 64'b01);
        walk_check("walk0");

        tie1 = 1;
        send(2'b01, 6'd2, 38'h2);
        check("ir_busy", 64'({busy, rsp_valid}), 64'b10);
        wait_rsp();
        check("ir_data", 64'(rsp_data), 64'h3);
        check("ir_err", 64'(rsp_error), 0);
        check("ir_ticks", 64'(tick_cnt - base), 8);
        check("ir_tms", seq(0, base, 8), 64'h63);
        check("ir_tdi", seq(1, base, 8), 64'h20);
        check("ir_tap", 64'(tap), RTI);
        handshake();

        send(2'b00, 6'd1, '1);
        wait_rsp();
        check("tlr_data", 64'(rsp_data), 0);
        check("tlr_err", 64'(rsp_error), 0);
        check("tlr_ticks", 64'(tick_cnt - base), 6);
        check("tlr_tms", seq(0, base, 6), 64'h1F);
        handshake();

        tie1 = 0;
        send(2'b10, 6'd38, DR_DATA);
        wait_rsp();
        check("dr_data", 64'(rsp_data), 64'(38'h14_B4B4_B4B5));
        check("dr_err", 64'(rsp_error), 0);
        check("dr_ticks", 64'(tick_cnt - base), 43);
        check("dr_tms", seq(0, base, 43), 64'h300_0000_0001);
        check("dr_tdi", seq(1, base + 3, 38), 64'(DR_DATA));
        check("dr_tap", 64'(tap), RTI);
        cmd_valid = 1; cmd_op = 2'b11; cmd_len = 6'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_data", 64'({rsp_error, rsp_data}), 64'(38'h14_B4B4_B4B5));
            check("hold_flags", 64'({rsp_valid, cmd_ready}), 64'b10);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("hold_release", 64'({rsp_valid, cmd_ready}), 64'b01);
        base = tick_cnt;
        @(negedge clk);
        cmd_valid = 0;
        check("op11_valid", 64'({rsp_valid, rsp_error}), 64'b11);
        check("op11_data", 64'(rsp_data), 0);
        check("op11_noticks", 64'(tick_cnt - base), 0);
        handshake();

        err_case("len0", 2'b10, 6'd0);
        err_case("len39", 2'b01, 6'd39);

        send(2'b10, 6'd38, DR_DATA);
        n = 0;
        while (tick_cnt < base + 13 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach", 64'(tick_cnt - base), 13);
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        check("abort_pins", 64'({tck, tms, tdi}), 64'b010);
        check("abort_flags", 64'({rsp_valid, cmd_ready, busy}), 64'b001);
        walk_check("walk1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
